// File: rtl/conv_window_controller_if.sv
// Handshake bundle between pixel source, controller and window consumer.
// master: source/consumer side (drives start, pixels, out_ready).
// slave: controller side (drives in_ready, shift strobe, window status).
interface conv_window_controller_if #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 6,
  parameter int DATA_WIDTH = 32
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic                  start;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  shift_en;
  logic [DATA_WIDTH-1:0] shift_data;
  logic                  window_valid;
  logic                  out_ready;
  logic [CW-1:0]         window_col;
  logic [RW-1:0]         window_row;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output start, in_data, in_valid, out_ready,
    input  in_ready, shift_en, shift_data, window_valid,
    input  window_col, window_row, busy, frame_done
  );

  modport slave (
    input  start, in_data, in_valid, out_ready,
    output in_ready, shift_en, shift_data, window_valid,
    output window_col, window_row, busy, frame_done
  );
endinterface

// File: rtl/conv_window_controller.sv
// Purpose: sequences a raster pixel stream into the KxK sliding-window shift bank
//          and flags complete in-bounds windows with their output coordinates.
// Latency: window_valid rises the cycle after the window-completing pixel is accepted.
// Backpressure: a pending, unconsumed window drops in_ready so no shift can corrupt it.
// Optional feature: define CONV_CTRL_STRIDE2_EN for stride-2 window production.
module conv_window_controller #(
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 6,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 32
) (
  input logic clock,
  input logic reset,
  conv_window_controller_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] KM1_C    = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] KM1_R    = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  window_valid_q;
  logic [CW-1:0]         win_col_q;
  logic [RW-1:0]         win_row_q;

  logic                  in_ready_c;
  logic                  accept;
  logic                  win_accept;
  logic [CW-1:0]         col_off;
  logic [RW-1:0]         row_off;
  logic [DATA_WIDTH-1:0] pix;

  // Accept only in RUN, and only when the held window is free or being taken now.
  assign in_ready_c = (state == RUN) && (!window_valid_q || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;

  // Output coordinate of the window this accept would complete.
  assign col_off = col - KM1_C;
  assign row_off = row - KM1_R;

`ifdef CONV_CTRL_STRIDE2_EN
  // Low bit of the offset is exact even after truncation, so it is the parity test.
  assign win_accept = accept && (col >= KM1_C) && (row >= KM1_R) && !col_off[0] && !row_off[0];
`else
  assign win_accept = accept && (col >= KM1_C) && (row >= KM1_R);
`endif

  assign pix            = bus.in_data;
  assign bus.shift_data = pix;
  assign bus.shift_en   = accept;
  assign bus.in_ready   = in_ready_c;
  assign bus.window_valid = window_valid_q;
  assign bus.window_col   = win_col_q;
  assign bus.window_row   = win_row_q;
  assign bus.busy         = busy_q;
  assign bus.frame_done   = frame_done_q;

  // Frame FSM with raster counters; busy and frame_done are registered with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            col    <= '0;
            row    <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row <= row + ROW_ONE;
              end
            end else begin
              col <= col + COL_ONE;
            end
          end
        end
        DRAIN: begin
          // Wait for the last window to be taken before declaring the frame done.
          if (!window_valid_q) begin
            state        <= DONE;
            frame_done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Window-valid flag and coordinates: a new window overrides a same-cycle consume.
  always_ff @(posedge clock) begin
    if (reset) begin
      window_valid_q <= 1'b0;
      win_col_q      <= '0;
      win_row_q      <= '0;
    end else if (win_accept) begin
      window_valid_q <= 1'b1;
      win_col_q      <= col_off;
      win_row_q      <= row_off;
    end else if (window_valid_q && bus.out_ready) begin
      window_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_controller.sv
// Directed bench for conv_window_controller: control-vector table plus frame sequences
// (full rate, backpressure, mid-frame reset, random in_valid gaps).
module tb_conv_window_controller;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 3;
  localparam int DW = 32;
`ifdef CONV_CTRL_STRIDE2_EN
  localparam int EXP_WIN = ((W - K) / 2 + 1) * ((H - K) / 2 + 1);
`else
  localparam int EXP_WIN = (W - K + 1) * (H - K + 1);
`endif
  localparam int FIRST_WIN_ACCEPTS = (K - 1) * W + K;

  logic clock;
  logic reset;

  conv_window_controller_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) bif ();

  conv_window_controller #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K), .DATA_WIDTH(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bif)
  );

  int checks   = 0;
  int failures = 0;
  bit bp_hit   = 0;

  typedef struct {
    int c;
    int r;
  } coord_t;
  coord_t exp_q[$];

  typedef struct {
    bit rst, st, iv, orr;
    bit e_ird, e_sh, e_busy, e_wv, e_fd;
  } vec_t;
  vec_t tv[7];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Runs one frame from IDLE. abort_at>0 stops right after that many accepts.
  task automatic run_frame(input bit gaps, input bit bp, input int abort_at);
    int accepts = 0, win_k = 0, fd_cnt = 0, cyc = 0, bp_left = 0, tail = 0;
    bit bp_done = 0, first_seen = 0, prev_shift = 0, wv_p1 = 0, wv_p2 = 0, done = 0;
    bif.start    = 1'b1;
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clock); #1;
    bif.start = 1'b0;
    while (!done && cyc < 3000) begin
      cyc++;
      if (bp && !bp_done && bp_left == 0 && bif.window_valid &&
          bif.window_col == 2 && bif.window_row == 1) begin
        bp_left = 5;
        bp_hit  = 1;
      end
      bif.out_ready = (bp_left == 0);
      if (accepts < W * H)
        bif.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      else
        bif.in_valid = 1'b1;
      bif.start   = (gaps && fd_cnt == 0 && accepts > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bif.in_data = DW'(32'hA500_0000 + accepts);
      #1;
      if (bp_left > 0) begin
        check("bp_in_ready", int'(bif.in_ready), 0);
        check("bp_shift_en", int'(bif.shift_en), 0);
        check("bp_col", int'(bif.window_col), 2);
        check("bp_row", int'(bif.window_row), 1);
        bp_left--;
        if (bp_left == 0) bp_done = 1;
      end
      if (bif.window_valid && !first_seen) begin
        first_seen = 1;
        check("first_win_accepts", accepts, FIRST_WIN_ACCEPTS);
        check("first_win_after_shift", int'(prev_shift), 1);
      end
      if (bif.window_valid && bif.out_ready) begin
        if (win_k < exp_q.size()) begin
          check("win_col", int'(bif.window_col), exp_q[win_k].c);
          check("win_row", int'(bif.window_row), exp_q[win_k].r);
        end else begin
          check("extra_window", win_k, exp_q.size() - 1);
        end
        win_k++;
      end
      if (bif.frame_done) begin
        fd_cnt++;
`ifndef CONV_CTRL_STRIDE2_EN
        check("fd_after_wv_fall", int'({wv_p2, wv_p1}), 2);
`endif
        check("fd_wv_low", int'(bif.window_valid), 0);
      end
      if (bif.shift_en) begin
        check("shift_data", int'(bif.shift_data), int'(bif.in_data));
        accepts++;
      end
      prev_shift = bif.shift_en;
      wv_p2 = wv_p1;
      wv_p1 = bif.window_valid;
      if (fd_cnt > 0) tail++;
      if (tail >= 3) done = 1;
      if (abort_at > 0 && accepts == abort_at) done = 1;
      @(posedge clock); #1;
    end
    bif.start = 1'b0;
    if (abort_at == 0) begin
      check("frame_done_pulses", fd_cnt, 1);
      check("window_count", win_k, EXP_WIN);
      check("accept_count", accepts, W * H);
      check("busy_end", int'(bif.busy), 0);
    end else begin
      check("abort_reached", accepts, abort_at);
    end
  endtask

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r >= K - 1 && c >= K - 1) begin
`ifdef CONV_CTRL_STRIDE2_EN
          if (((c - (K - 1)) % 2 == 0) && ((r - (K - 1)) % 2 == 0))
            exp_q.push_back('{c - (K - 1), r - (K - 1)});
`else
          exp_q.push_back('{c - (K - 1), r - (K - 1)});
`endif
        end

    //          rst st iv or | ird sh busy wv fd
    tv[0] = '{0, 0, 1, 1,   0, 0, 0, 0, 0};  // IDLE ignores in_valid
    tv[1] = '{0, 1, 0, 1,   0, 0, 0, 0, 0};  // start sampled at this edge
    tv[2] = '{0, 0, 0, 1,   1, 0, 1, 0, 0};  // RUN: ready, no valid, no shift
    tv[3] = '{0, 1, 0, 1,   1, 0, 1, 0, 0};  // start while busy ignored
    tv[4] = '{0, 0, 1, 1,   1, 1, 1, 0, 0};  // first accept
    tv[5] = '{1, 0, 1, 1,   1, 1, 1, 0, 0};  // reset applied mid-frame
    tv[6] = '{0, 0, 1, 1,   0, 0, 0, 0, 0};  // aborted: IDLE, nothing accepted

    reset = 1'b1;
    bif.start = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    bif.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", int'(bif.busy), 0);
    check("rst_wv", int'(bif.window_valid), 0);
    check("rst_fd", int'(bif.frame_done), 0);
    check("rst_in_ready", int'(bif.in_ready), 0);
    check("rst_shift_en", int'(bif.shift_en), 0);
    check("rst_col", int'(bif.window_col), 0);
    check("rst_row", int'(bif.window_row), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      reset         = tv[i].rst;
      bif.start     = tv[i].st;
      bif.in_valid  = tv[i].iv;
      bif.out_ready = tv[i].orr;
      bif.in_data   = DW'(i);
      #1;
      check($sformatf("vec%0d_in_ready", i), int'(bif.in_ready), int'(tv[i].e_ird));
      check($sformatf("vec%0d_shift_en", i), int'(bif.shift_en), int'(tv[i].e_sh));
      check($sformatf("vec%0d_busy", i), int'(bif.busy), int'(tv[i].e_busy));
      check($sformatf("vec%0d_wv", i), int'(bif.window_valid), int'(tv[i].e_wv));
      check($sformatf("vec%0d_fd", i), int'(bif.frame_done), int'(tv[i].e_fd));
      @(posedge clock); #1;
    end
    reset = 1'b0;
    bif.start = 1'b0;
    bif.in_valid = 1'b0;

    run_frame(0, 0, 0);

    run_frame(0, 1, 0);
`ifndef CONV_CTRL_STRIDE2_EN
    check("bp_window_seen", int'(bp_hit), 1);
`endif

    run_frame(0, 0, 30);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", int'(bif.busy), 0);
    check("abort_wv", int'(bif.window_valid), 0);
    check("abort_fd", int'(bif.frame_done), 0);
    check("abort_shift_en", int'(bif.shift_en), 0);
    bif.in_valid = 1'b0;
    @(posedge clock); #1;
    check("abort_no_late_fd", int'(bif.frame_done), 0);

    run_frame(0, 0, 0);
    run_frame(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
